// File: rtl/sram_burst_reader_if.sv
// sram_burst_reader_if: command, SRAM read port and output stream of the
// burst read sequencer, bundled as one interface.
//
// Optional feature macro: SRAM_BURST_READER_STRIDE_EN (adds cmd_stride).
//
// Signals:
//   cmd_valid/cmd_ready        burst command handshake
//   cmd_base [L_ADDR]          first word address
//   cmd_len  [L_LEN]           word count, 0..NB_DATA
//   cmd_stride [L_ADDR]        address step (only with the stride macro)
//   rEn                        SRAM read enable, active-low
//   rAddr [L_ADDR]             SRAM read address
//   rData [L_DATA]             SRAM read data, one cycle after the read edge
//   out_valid/out_ready        output word handshake
//   out_data [L_DATA]          output word
//   out_last                   final word of the burst
//
// Modports:
//   master  the sequencer side
//   slave   the command source / SRAM / consumer side
interface sram_burst_reader_if #(
  parameter int unsigned L_DATA = 16,
  parameter int unsigned L_ADDR = 13,
  parameter int unsigned L_LEN  = 14
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [L_ADDR-1:0] cmd_base;
  logic [L_LEN-1:0]  cmd_len;
`ifdef SRAM_BURST_READER_STRIDE_EN
  logic [L_ADDR-1:0] cmd_stride;
`endif

  logic              rEn;
  logic [L_ADDR-1:0] rAddr;
  logic [L_DATA-1:0] rData;

  logic              out_valid;
  logic              out_ready;
  logic [L_DATA-1:0] out_data;
  logic              out_last;

  modport master (
    input  cmd_valid,
    input  cmd_base,
    input  cmd_len,
`ifdef SRAM_BURST_READER_STRIDE_EN
    input  cmd_stride,
`endif
    output cmd_ready,
    output rEn,
    output rAddr,
    input  rData,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    output cmd_valid,
    output cmd_base,
    output cmd_len,
`ifdef SRAM_BURST_READER_STRIDE_EN
    output cmd_stride,
`endif
    input  cmd_ready,
    input  rEn,
    input  rAddr,
    output rData,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/sram_burst_reader.sv
// sram_burst_reader: read-side sequencer for the banked NB_DATA x L_DATA SRAM
// buffer. Takes a (base, len) burst command, issues one read per cycle on the
// active-low rEn/rAddr port, captures rData one cycle later into a 2-entry
// skid FIFO and streams the words out over valid/ready.
//
// Optional feature macro: SRAM_BURST_READER_STRIDE_EN
//   defined   : cmd_stride is latched with the command; address advances by it
//   undefined : address advances by 1
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   bus        sram_burst_reader_if.master (command, SRAM read port, output)
//   busy       state != IDLE
//   done       one-cycle pulse at burst completion
module sram_burst_reader #(
  parameter int unsigned NB_DATA = 8192,
  parameter int unsigned L_DATA  = 16,
  parameter int unsigned L_ADDR  = 13,
  parameter int unsigned L_LEN   = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_burst_reader_if.master bus,
  output logic                busy,
  output logic                done
);

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned L_CNT      = 2;
  localparam int unsigned L_OCC      = 3;
  localparam int unsigned L_SUM      = L_ADDR + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } stateT;

  stateT             state;
  stateT             stateNext;

  logic [L_ADDR-1:0] addr;
  logic [L_ADDR-1:0] addrNext;
  logic [L_SUM-1:0]  addrSum;
  logic [L_ADDR-1:0] stride;
  logic [L_LEN-1:0]  remaining;
  logic [L_LEN-1:0]  lenSat;

  logic              inflight;
  logic              inflightLast;

  logic [L_DATA-1:0] fifoData [FIFO_DEPTH];
  logic              fifoLast [FIFO_DEPTH];
  logic              rdPtr;
  logic              wrPtr;
  logic [L_CNT-1:0]  fifoCount;
  logic [L_OCC-1:0]  occupancy;

  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;
  logic              outValid;
  logic              cmdReadyQ;

  // Over-long commands are clamped to a full pass over the buffer.
  assign lenSat = (bus.cmd_len > L_LEN'(NB_DATA)) ? L_LEN'(NB_DATA) : bus.cmd_len;

  // Next address modulo NB_DATA; both operands are < NB_DATA so one
  // conditional subtract is enough.
  assign addrSum  = L_SUM'(addr) + L_SUM'(stride);
  assign addrNext = (addrSum >= L_SUM'(NB_DATA)) ? L_ADDR'(addrSum - L_SUM'(NB_DATA))
                                                 : L_ADDR'(addrSum);

`ifdef SRAM_BURST_READER_STRIDE_EN
  logic [L_ADDR-1:0] strideQ;

  // Stride is held for the whole burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strideQ <= '0;
    end else if (accept) begin
      strideQ <= bus.cmd_stride;
    end
  end

  assign stride = strideQ;
`else
  assign stride = L_ADDR'(1);
`endif

  // FIFO handshake: a captured word is pushed the cycle after its read edge.
  assign outValid = (fifoCount != '0);
  assign pop      = outValid & bus.out_ready;
  assign push     = inflight;

  // Words owned after this edge: stored + returning - leaving. pop implies a
  // non-empty FIFO, so this never underflows.
  assign occupancy = L_OCC'(fifoCount) + L_OCC'(inflight) - L_OCC'(pop);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and read-issue decode.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept    = 1'b1;
          stateNext = (bus.cmd_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (remaining == '0) begin
          stateNext = DRAIN;
        end else begin
          issue = (occupancy < L_OCC'(FIFO_DEPTH));
          if (issue && (remaining == L_LEN'(1))) begin
            stateNext = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Leave once nothing is returning and the FIFO empties at this edge.
        if (!inflight && ((fifoCount == '0) || ((fifoCount == L_CNT'(1)) && pop))) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // SRAM port is driven in the issue cycle so the SRAM samples it this edge.
  assign bus.rEn   = ~issue;
  assign bus.rAddr = issue ? addr : '0;

  // Burst address/count and read-return tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr         <= '0;
      remaining    <= '0;
      inflight     <= 1'b0;
      inflightLast <= 1'b0;
    end else begin
      if (accept) begin
        addr      <= bus.cmd_base;
        remaining <= lenSat;
      end else if (issue) begin
        addr      <= addrNext;
        remaining <= remaining - L_LEN'(1);
      end
      inflight     <= issue;
      inflightLast <= issue && (remaining == L_LEN'(1));
    end
  end

  // Two-entry skid FIFO; the head entry drives the output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifoData[i] <= '0;
        fifoLast[i] <= 1'b0;
      end
      rdPtr     <= 1'b0;
      wrPtr     <= 1'b0;
      fifoCount <= '0;
    end else begin
      if (push) begin
        fifoData[wrPtr] <= bus.rData;
        fifoLast[wrPtr] <= inflightLast;
        wrPtr           <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      unique case ({push, pop})
        2'b10:   fifoCount <= fifoCount + L_CNT'(1);
        2'b01:   fifoCount <= fifoCount - L_CNT'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // The issue rule must keep the FIFO from ever overflowing.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && (fifoCount == L_CNT'(FIFO_DEPTH))));
    end
  end

  // Status flags, registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmdReadyQ <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cmdReadyQ <= (stateNext == IDLE);
      busy      <= (stateNext != IDLE);
      done      <= (stateNext == DONE);
    end
  end

  assign bus.cmd_ready = cmdReadyQ;
  assign bus.out_valid = outValid;
  assign bus.out_data  = fifoData[rdPtr];
  assign bus.out_last  = fifoLast[rdPtr];

endmodule

// File: doc/sram_burst_reader.md
Name: sram_burst_reader

Overview:
- Read-side sequencer sitting directly upstream of the banked 8192x16 SRAM buffer wrapper.
- Accepts a burst command (base address, word count) and drives the wrapper's rEn/rAddr port.
- Captures rData one cycle after each issued read and streams the words to the downstream consumer over a valid/ready handshake.
- Holds a 2-entry output skid FIFO so that 1 word/cycle is sustained under backpressure without read overrun.

Parameters:
- NB_DATA, 8192, SRAM depth in words
- L_DATA, 16, word width
- L_ADDR, 13, address width; equals clog2(NB_DATA)
- L_LEN, 14, burst-length width; must hold NB_DATA

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  high only in IDLE
- cmd_base  in  L_ADDR  first word address
- cmd_len  in  L_LEN  word count, 0..NB_DATA
- rEn  out  1  SRAM read enable, ACTIVE-LOW (1 = no read)
- rAddr  out  L_ADDR  SRAM read address
- rData  in  L_DATA  SRAM read data, valid the cycle after the read edge
- out_valid  out  1  output word valid
- out_ready  in  1  consumer ready
- out_data  out  L_DATA  output word
- out_last  out  1  final word of burst, qualified by out_valid
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, rEn=1, rAddr=0, FIFO emptied, in-flight flag cleared, out_valid=0, out_last=0, out_data=0, done=0, busy=0.
- Reset asserted mid-burst: aborts the burst. Data returning the following cycle is discarded and no done pulse is produced.
- Clocking and reset: one clock domain; reset is synchronous and active-low.
- States:
  - IDLE: cmd_ready=1. When cmd_valid is high, latch base/len and go to RUN. If len==0, go to DONE instead.
  - RUN: issue reads until the remaining count is 0, then go to DRAIN.
  - DRAIN: wait until the in-flight flag is clear and the FIFO is empty, then go to DONE.
  - DONE: assert done for one cycle, return to IDLE.
- Read issue rule, evaluated each RUN cycle:
  - issue when remaining>0 AND (fifo_count + inflight − pop) < 2, where pop = out_valid & out_ready.
  - On issue: rEn=0 and rAddr=current address; remaining decrements and address increments. The address wraps modulo NB_DATA (8191 → 0).
  - rEn and rAddr are combinational from registered state and the pop term, so the SRAM samples them at the same edge.
- Capture: inflight is set on an issue edge. At the next edge rData is written into the FIFO and inflight is cleared, or set again if a new read issued.
- FIFO:
  - 2 entries; the head drives out_data.
  - out_valid = FIFO non-empty.
  - Simultaneous push and pop is legal; count is unchanged.
  - The FIFO never overflows (guaranteed by the issue rule). Overflow is an assertion failure.
- out_last: tagged on the entry captured from the read issued when remaining==1.
- Latency: cmd accepted at edge T → first rEn=0 in cycle T+1 → out_valid high after edge T+2.
- Throughput: with out_ready held high, 1 word/cycle. A burst of N words completes with done high in cycle T+N+3.
- done: asserted the cycle after the last word pops. cmd_ready rises the cycle after done.
- Commands presented while busy are ignored (cmd_ready=0).
- cmd_len>NB_DATA is illegal. The sequencer saturates it to NB_DATA.

Optional Feature:
- Macro SRAM_BURST_READER_STRIDE_EN.
- Defined: adds input port cmd_stride [L_ADDR-1:0], latched with the command. The address advances by stride modulo NB_DATA; stride 0 rereads cmd_base N times.
- Undefined: port absent, stride fixed at 1.

Test Plan:
- Basic burst: base=0x0010, len=4, out_ready=1 → rAddr 0x10..0x13 in consecutive cycles; out_data equals the preloaded words; out_last on the 4th word; done in cycle T+7.
- Wrap: base=8190, len=4 → rAddr sequence 8190, 8191, 0, 1; data in order.
- Backpressure: len=8, out_ready toggling 1,0,0,1,… → no word lost or duplicated; FIFO count ≤2; rEn held 1 while the FIFO is full plus in-flight.
- Zero length: len=0 → no rEn=0 cycle; done pulses; cmd_ready back after 2 cycles.
- Reset mid-burst: rst_n low at word 3 of 16 → next cycle rEn=1, out_valid=0, busy=0, no done; new command after reset works from a clean state.
- Stride (macro defined): base=100, stride=7, len=3 → rAddr 100, 107, 114.
